// File: rtl/pool_engine.sv
// Streaming max/average pooling of 2^win_log2 SA beats per lane, full-width or split into two lanes.
// Result registered 1 cycle after the last beat; input stalls while an unconsumed result is held.
module pool_engine #(
    parameter int DATA_WIDTH   = 14,
    parameter int MAX_WIN_LOG2 = 4,
    parameter int WL_W         = $clog2(MAX_WIN_LOG2 + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pool_enable,
    input  logic                  out_model,
    input  logic                  Sx,
    input  logic                  avg_mode,
    input  logic [WL_W-1:0]       win_log2,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] input_from_SA,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] max_out
);
    localparam int LW = DATA_WIDTH / 2;
    localparam int AW = DATA_WIDTH + MAX_WIN_LOG2;
    localparam int CW = MAX_WIN_LOG2;

    logic [CW-1:0]         cnt_q, cnt_d;
    logic [AW-1:0]         acc_lo_q, acc_lo_d, acc_hi_q, acc_hi_d;
    logic                  cfg_model_q, cfg_model_d, cfg_sx_q, cfg_sx_d, cfg_avg_q, cfg_avg_d;
    logic [WL_W-1:0]       cfg_wl_q, cfg_wl_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] res_q, res_d;

    logic                  accept, consume, first, last;
    logic                  model, sx, avg;
    logic [WL_W-1:0]       wl_in, wl;
    logic [CW:0]           win_len;
    logic [AW-1:0]         ext_lo, ext_hi, comb_lo, comb_hi, red_lo, red_hi;

    // Operands are already extended to AW, so one compare serves both lane widths.
    function automatic logic [AW-1:0] merge(input logic [AW-1:0] a, input logic [AW-1:0] b,
                                            input logic is_signed, input logic is_avg);
        logic greater;
        greater = is_signed ? ($signed(a) > $signed(b)) : (a > b);
        if (is_avg)
            return a + b;
        return greater ? a : b;
    endfunction

    function automatic logic [AW-1:0] scale(input logic [AW-1:0] s, input logic is_signed,
                                            input logic is_avg, input logic [WL_W-1:0] sh);
        logic signed [AW-1:0] s_sgn;
        s_sgn = $signed(s) >>> sh;
        if (!is_avg)
            return s;
        return is_signed ? $unsigned(s_sgn) : (s >> sh);
    endfunction

    assign in_ready  = pool_enable && (!out_valid_q || out_ready);
    assign out_valid = out_valid_q;
    assign max_out   = res_q;

    always_comb begin
        accept  = in_valid && in_ready;
        consume = out_valid_q && out_ready;
        first   = (cnt_q == '0);
        wl_in   = (win_log2 > WL_W'(MAX_WIN_LOG2)) ? WL_W'(MAX_WIN_LOG2) : win_log2;
        // Live config applies to the first beat; later beats use the latched copy.
        model   = first ? out_model : cfg_model_q;
        sx      = first ? Sx        : cfg_sx_q;
        avg     = first ? avg_mode  : cfg_avg_q;
        wl      = first ? wl_in     : cfg_wl_q;
        win_len = (CW+1)'(1) << wl;
        last    = ({1'b0, cnt_q} == win_len - 1'b1);

        ext_lo = model ? {{MAX_WIN_LOG2{sx & input_from_SA[DATA_WIDTH-1]}}, input_from_SA}
                       : {{(AW-LW){sx & input_from_SA[LW-1]}}, input_from_SA[LW-1:0]};
        ext_hi = {{(AW-LW){sx & input_from_SA[DATA_WIDTH-1]}}, input_from_SA[DATA_WIDTH-1:LW]};
        comb_lo = first ? ext_lo : merge(acc_lo_q, ext_lo, sx, avg);
        comb_hi = first ? ext_hi : merge(acc_hi_q, ext_hi, sx, avg);
        red_lo  = scale(comb_lo, sx, avg, wl);
        red_hi  = scale(comb_hi, sx, avg, wl);

        cnt_d       = cnt_q;
        acc_lo_d    = acc_lo_q;
        acc_hi_d    = acc_hi_q;
        cfg_model_d = cfg_model_q;
        cfg_sx_d    = cfg_sx_q;
        cfg_avg_d   = cfg_avg_q;
        cfg_wl_d    = cfg_wl_q;
        out_valid_d = out_valid_q;
        res_d       = res_q;

        if (consume) begin
            out_valid_d = 1'b0;
            res_d       = '0;
        end

        if (!pool_enable) begin
            cnt_d    = '0;
            acc_lo_d = '0;
            acc_hi_d = '0;
        end else if (accept) begin
            if (first) begin
                cfg_model_d = model;
                cfg_sx_d    = sx;
                cfg_avg_d   = avg;
                cfg_wl_d    = wl;
            end
            if (last) begin
                cnt_d       = '0;
                acc_lo_d    = '0;
                acc_hi_d    = '0;
                out_valid_d = 1'b1;
                res_d       = model ? red_lo[DATA_WIDTH-1:0] : {red_hi[LW-1:0], red_lo[LW-1:0]};
            end else begin
                cnt_d    = cnt_q + 1'b1;
                acc_lo_d = comb_lo;
                acc_hi_d = comb_hi;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q       <= '0;
            acc_lo_q    <= '0;
            acc_hi_q    <= '0;
            cfg_model_q <= 1'b0;
            cfg_sx_q    <= 1'b0;
            cfg_avg_q   <= 1'b0;
            cfg_wl_q    <= '0;
            out_valid_q <= 1'b0;
            res_q       <= '0;
        end else begin
            cnt_q       <= cnt_d;
            acc_lo_q    <= acc_lo_d;
            acc_hi_q    <= acc_hi_d;
            cfg_model_q <= cfg_model_d;
            cfg_sx_q    <= cfg_sx_d;
            cfg_avg_q   <= cfg_avg_d;
            cfg_wl_q    <= cfg_wl_d;
            out_valid_q <= out_valid_d;
            res_q       <= res_d;
        end
    end
endmodule

// File: tb/tb_pool_engine.sv
// Bench for pool_engine: window-level reference model checked every cycle plus directed literal checks.
module tb_pool_engine;
    localparam int DW = 14;
    localparam int MW = 4;
    localparam int WW = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          pool_enable = 1'b0;
    logic          out_model = 1'b1;
    logic          Sx = 1'b0;
    logic          avg_mode = 1'b0;
    logic [WW-1:0] win_log2 = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] input_from_SA = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] max_out;

    int n_pass = 0;
    int n_total = 0;
    bit running = 1'b0;

    pool_engine #(.DATA_WIDTH(DW), .MAX_WIN_LOG2(MW), .WL_W(WW)) dut (
        .clk(clk), .reset(reset), .pool_enable(pool_enable), .out_model(out_model),
        .Sx(Sx), .avg_mode(avg_mode), .win_log2(win_log2), .in_valid(in_valid),
        .in_ready(in_ready), .input_from_SA(input_from_SA), .out_valid(out_valid),
        .out_ready(out_ready), .max_out(max_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    endtask

    // Reference model: the current window is a list of raw beats; the result is
    // recomputed from the whole list with integer arithmetic when the window fills.
    logic [DW-1:0] win_q[$];
    bit m_model = 1'b0, m_sx = 1'b0, m_avg = 1'b0;
    int m_wl = 0;
    bit m_valid = 1'b0;
    int m_res = 0;

    function automatic int lane_red(input int lo, input int w);
        int n, v, sum, mx;
        n = win_q.size();
        sum = 0;
        mx = 0;
        v = 0;
        foreach (win_q[i]) begin
            v = (int'(win_q[i]) >> lo) & ((1 << w) - 1);
            if (m_sx && v >= (1 << (w - 1)))
                v -= (1 << w);
            sum += v;
            if (i == 0 || v > mx)
                mx = v;
        end
        if (m_avg)
            v = (sum >= 0) ? sum / n : -((-sum + n - 1) / n);
        else
            v = mx;
        return v & ((1 << w) - 1);
    endfunction

    always @(posedge clk or negedge reset) begin
        bit acc;
        bit cons;
        bit done;
        if (!reset) begin
            win_q.delete();
            m_valid = 1'b0;
            m_res = 0;
        end else begin
            acc  = in_valid && pool_enable && (!m_valid || out_ready);
            cons = m_valid && out_ready;
            done = 1'b0;
            if (!pool_enable) begin
                win_q.delete();
            end else if (acc) begin
                if (win_q.size() == 0) begin
                    m_model = out_model;
                    m_sx    = Sx;
                    m_avg   = avg_mode;
                    m_wl    = (int'(win_log2) > MW) ? MW : int'(win_log2);
                end
                win_q.push_back(input_from_SA);
                if (win_q.size() == (1 << m_wl)) begin
                    m_res = m_model ? lane_red(0, DW) : ((lane_red(DW/2, DW/2) << (DW/2)) | lane_red(0, DW/2));
                    done = 1'b1;
                    win_q.delete();
                end
            end
            if (done)
                m_valid = 1'b1;
            else if (cons) begin
                m_valid = 1'b0;
                m_res = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (running) begin
            chk("in_ready",  in_ready,  pool_enable && (!m_valid || out_ready));
            chk("out_valid", out_valid, m_valid);
            chk("max_out",   max_out,   m_valid ? m_res : 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic beat(input logic [DW-1:0] d);
        in_valid = 1'b1;
        input_from_SA = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    initial begin
        #1 reset = 1'b0;
        running = 1'b1;
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_max_out", max_out, 0);
        chk("rst_in_ready", in_ready, 0);
        tick();
        tick();
        reset = 1'b1;

        // Full-width signed max, all-negative window
        pool_enable = 1; out_ready = 1; out_model = 1; Sx = 1; avg_mode = 0; win_log2 = 2;
        beat(14'h3FFB);
        beat(14'h3FFD);
        in_valid = 1; input_from_SA = 14'h3FF7;
        at_neg();
        chk("t1_not_yet_valid", out_valid, 0);
        chk("t1_not_yet_out", max_out, 0);
        tick();
        beat(14'h3FF9);
        at_neg();
        chk("t1_valid", out_valid, 1);
        chk("t1_max", max_out, 14'h3FFD);
        tick();
        at_neg();
        chk("t1_consumed", out_valid, 0);

        // Split unsigned average
        out_model = 0; Sx = 0; avg_mode = 1; win_log2 = 1;
        beat(14'h0503);
        beat(14'h0684);
        at_neg();
        chk("t2_split_uavg", max_out, 14'h0583);
        tick();

        // Split signed average floors toward -inf; then unsigned hi lane 127
        Sx = 1;
        beat(14'h007D);
        beat(14'h007E);
        at_neg();
        chk("t3_split_savg", max_out, 14'h007D);
        tick();
        Sx = 0;
        beat(14'h3F80);
        beat(14'h3F80);
        at_neg();
        chk("t3_hi_127", max_out, 14'h3F80);
        tick();

        // Backpressure
        out_model = 1; Sx = 0; avg_mode = 0; win_log2 = 1; out_ready = 0;
        beat(14'd5);
        beat(14'd9);
        in_valid = 1; input_from_SA = 14'h20;
        for (int i = 0; i < 3; i++) begin
            at_neg();
            chk("t4_stall_in_ready", in_ready, 0);
            chk("t4_hold_max", max_out, 9);
        end
        tick();
        out_ready = 1;
        at_neg();
        chk("t4_ready_again", in_ready, 1);
        tick();
        beat(14'd7);
        at_neg();
        chk("t4_same_edge_beat", max_out, 14'h20);
        tick();

        // Passthrough, back-to-back completion and consume
        win_log2 = 0;
        beat(14'd1);
        beat(14'd2);
        beat(14'd3);
        at_neg();
        chk("t5_passthru", max_out, 3);
        tick();

        // pool_enable flush, then mid-window win_log2 change ignored
        win_log2 = 2;
        beat(14'd100);
        beat(14'd200);
        pool_enable = 0;
        tick();
        tick();
        at_neg();
        chk("t6_disabled_in_ready", in_ready, 0);
        pool_enable = 1;
        beat(14'd1);
        beat(14'd2);
        win_log2 = 1;
        beat(14'd3);
        at_neg();
        chk("t6_no_early_result", out_valid, 0);
        beat(14'd4);
        at_neg();
        chk("t6_valid", out_valid, 1);
        chk("t6_max", max_out, 4);
        tick();

        // Async reset while a result is held, then mid-window
        out_ready = 0; win_log2 = 0;
        beat(14'h0AA);
        @(posedge clk);
        #3 reset = 0;
        #1;
        chk("t7_async_valid", out_valid, 0);
        chk("t7_async_max", max_out, 0);
        tick();
        reset = 1;
        out_ready = 1; win_log2 = 2;
        beat(14'h10);
        beat(14'h11);
        @(posedge clk);
        #3 reset = 0;
        #1;
        chk("t7_midwin_valid", out_valid, 0);
        tick();
        reset = 1;
        win_log2 = 0;
        beat(14'h1234);
        at_neg();
        chk("t7_after_valid", out_valid, 1);
        chk("t7_after_max", max_out, 14'h1234);
        tick();
        tick();

        running = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
